// File: rtl/instr_dispatch.sv
// In-order instruction dispatcher: a circular FIFO of raw instructions whose head is decoded
// and routed to either the regular or the weight port; NOP entries are dropped at the head.
module instr_dispatch #(
   parameter int BUFFER_ADDR_WIDTH = 24,
   parameter int ACC_ADDR_WIDTH    = 16,
   parameter int LENGTH_WIDTH      = 32,
   parameter int OPCODE_WIDTH      = 8,
   parameter int FIFO_DEPTH        = 8,
   localparam int IW = BUFFER_ADDR_WIDTH + ACC_ADDR_WIDTH + LENGTH_WIDTH + OPCODE_WIDTH,
   localparam int CW = $clog2(FIFO_DEPTH + 1)
) (
   input  logic                                      clk,
   input  logic                                      rst_n,
   input  logic                                      in_valid,
   output logic                                      in_ready,
   input  logic [IW-1:0]                             in_bits,
   input  logic                                      flush,
   output logic                                      instr_valid,
   input  logic                                      instr_ready,
   output logic [BUFFER_ADDR_WIDTH-1:0]              instr_buffer_addr,
   output logic [ACC_ADDR_WIDTH-1:0]                 instr_acc_addr,
   output logic [LENGTH_WIDTH-1:0]                   instr_length,
   output logic [OPCODE_WIDTH-1:0]                   instr_opcode,
   output logic                                      weight_valid,
   input  logic                                      weight_ready,
   output logic [BUFFER_ADDR_WIDTH+ACC_ADDR_WIDTH-1:0] weight_addr,
   output logic [LENGTH_WIDTH-1:0]                   weight_length,
   output logic [OPCODE_WIDTH-1:0]                   weight_opcode,
   output logic [CW-1:0]                             count,
   output logic                                      empty,
   output logic                                      full
);

   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

   logic [IW-1:0] mem_q [FIFO_DEPTH];
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [CW-1:0] count_q, count_d;

   logic [IW-1:0]                head;
   logic [BUFFER_ADDR_WIDTH-1:0] head_buffer_addr;
   logic [ACC_ADDR_WIDTH-1:0]    head_acc_addr;
   logic [LENGTH_WIDTH-1:0]      head_length;
   logic [OPCODE_WIDTH-1:0]      head_opcode;
   logic                         head_nop, head_weight, head_regular;
   logic                         push, pop;

   // Handshakes: a transfer happens on a cycle where valid && ready are both high; valid never
   // depends on ready, and the head payload stays stable while its valid waits for ready.
   assign head             = mem_q[rd_ptr_q];
   assign head_buffer_addr = head[IW-1 -: BUFFER_ADDR_WIDTH];
   assign head_acc_addr    = head[IW-BUFFER_ADDR_WIDTH-1 -: ACC_ADDR_WIDTH];
   assign head_length      = head[OPCODE_WIDTH +: LENGTH_WIDTH];
   assign head_opcode      = head[OPCODE_WIDTH-1:0];

   assign head_nop     = (head_opcode == '0);
   assign head_weight  = head_opcode[OPCODE_WIDTH-1];
   assign head_regular = !head_nop && !head_weight;

   assign empty    = (count_q == '0);
   assign full     = (count_q == DEPTH_C);
   assign count    = count_q;
   assign in_ready = !full;

   assign instr_valid  = !empty && head_regular;
   assign weight_valid = !empty && head_weight;

   assign instr_buffer_addr = head_buffer_addr;
   assign instr_acc_addr    = head_acc_addr;
   assign instr_length      = head_length;
   assign instr_opcode      = head_opcode;
   assign weight_addr       = {head_buffer_addr, head_acc_addr};
   assign weight_length     = head_length;
   assign weight_opcode     = head_opcode;

   // NOPs retire on their own so they never reach either port; flush suppresses both sides.
   assign push = in_valid && !full && !flush;
   assign pop  = !flush && !empty &&
                 (head_nop || (head_weight && weight_ready) || (head_regular && instr_ready));

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (flush) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
         case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage is not reset; occupancy alone decides what is valid.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= in_bits;
   end

endmodule

// File: tb/tb_instr_dispatch.sv
// Directed self-checking bench for instr_dispatch with default parameters.
module tb_instr_dispatch;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [79:0] in_bits;
   logic        flush;
   logic        instr_valid;
   logic        instr_ready;
   logic [23:0] instr_buffer_addr;
   logic [15:0] instr_acc_addr;
   logic [31:0] instr_length;
   logic [7:0]  instr_opcode;
   logic        weight_valid;
   logic        weight_ready;
   logic [39:0] weight_addr;
   logic [31:0] weight_length;
   logic [7:0]  weight_opcode;
   logic [3:0]  count;
   logic        empty;
   logic        full;

   int n_checks = 0;
   int n_fail   = 0;

   instr_dispatch dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .in_valid          (in_valid),
      .in_ready          (in_ready),
      .in_bits           (in_bits),
      .flush             (flush),
      .instr_valid       (instr_valid),
      .instr_ready       (instr_ready),
      .instr_buffer_addr (instr_buffer_addr),
      .instr_acc_addr    (instr_acc_addr),
      .instr_length      (instr_length),
      .instr_opcode      (instr_opcode),
      .weight_valid      (weight_valid),
      .weight_ready      (weight_ready),
      .weight_addr       (weight_addr),
      .weight_length     (weight_length),
      .weight_opcode     (weight_opcode),
      .count             (count),
      .empty             (empty),
      .full              (full)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [79:0] mk(input logic [23:0] ba, input logic [15:0] aa,
                                      input logic [31:0] ln, input logic [7:0] op);
      return {ba, aa, ln, op};
   endfunction

   // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      #2;
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
      n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b expected 1", empty); end
      n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b expected 0", full); end
      n_checks++; if (count !== 4'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", count); end
      n_checks++; if (instr_valid !== 1'b0 || weight_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valids: got %b%b expected 00", instr_valid, weight_valid); end
      step();
      rst_n = 1'b1;
   endtask

   task automatic test_regular();
      in_valid = 1'b1; in_bits = 80'h000010_0002_00000040_01; instr_ready = 1'b1;
      step();
      in_valid = 1'b0;
      n_checks++; if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL reg_valid: got %b expected 1", instr_valid); end
      n_checks++; if (weight_valid !== 1'b0) begin n_fail++; $display("FAIL reg_wvalid: got %b expected 0", weight_valid); end
      n_checks++; if (instr_buffer_addr !== 24'h10) begin n_fail++; $display("FAIL reg_baddr: got %h expected 000010", instr_buffer_addr); end
      n_checks++; if (instr_acc_addr !== 16'h2) begin n_fail++; $display("FAIL reg_aaddr: got %h expected 0002", instr_acc_addr); end
      n_checks++; if (instr_length !== 32'h40) begin n_fail++; $display("FAIL reg_len: got %h expected 00000040", instr_length); end
      n_checks++; if (instr_opcode !== 8'h01) begin n_fail++; $display("FAIL reg_op: got %h expected 01", instr_opcode); end
      n_checks++; if (count !== 4'd1) begin n_fail++; $display("FAIL reg_count: got %0d expected 1", count); end
      step();
      n_checks++; if (empty !== 1'b1 || instr_valid !== 1'b0) begin n_fail++; $display("FAIL reg_popped: got empty=%b valid=%b expected 1 0", empty, instr_valid); end
      instr_ready = 1'b0;
   endtask

   task automatic test_weight();
      in_valid = 1'b1; in_bits = mk(24'hABCDEF, 16'h1234, 32'h99, 8'h81); weight_ready = 1'b0;
      step();
      in_valid = 1'b0;
      n_checks++; if (weight_valid !== 1'b1) begin n_fail++; $display("FAIL wt_valid: got %b expected 1", weight_valid); end
      n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL wt_ivalid: got %b expected 0", instr_valid); end
      n_checks++; if (weight_addr !== 40'hABCDEF1234) begin n_fail++; $display("FAIL wt_addr: got %h expected abcdef1234", weight_addr); end
      n_checks++; if (weight_length !== 32'h99 || weight_opcode !== 8'h81) begin n_fail++; $display("FAIL wt_len_op: got %h %h expected 00000099 81", weight_length, weight_opcode); end
      step();
      n_checks++; if (weight_valid !== 1'b1 || count !== 4'd1 || weight_addr !== 40'hABCDEF1234) begin n_fail++; $display("FAIL wt_hold: got valid=%b count=%0d addr=%h expected 1 1 abcdef1234", weight_valid, count, weight_addr); end
      weight_ready = 1'b1;
      step();
      n_checks++; if (empty !== 1'b1 || weight_valid !== 1'b0) begin n_fail++; $display("FAIL wt_popped: got empty=%b valid=%b expected 1 0", empty, weight_valid); end
      weight_ready = 1'b0;
   endtask

   task automatic test_back_to_back();
      instr_ready = 1'b1; weight_ready = 1'b1;
      in_valid = 1'b1; in_bits = mk(24'h1, 16'h1, 32'h1, 8'h00);
      step();
      n_checks++; if (instr_valid !== 1'b0 || weight_valid !== 1'b0 || count !== 4'd1) begin n_fail++; $display("FAIL b2b_nop: got iv=%b wv=%b count=%0d expected 0 0 1", instr_valid, weight_valid, count); end
      in_bits = mk(24'h222, 16'h22, 32'h20, 8'h05);
      step();
      n_checks++; if (instr_valid !== 1'b1 || weight_valid !== 1'b0 || instr_opcode !== 8'h05 || count !== 4'd1) begin n_fail++; $display("FAIL b2b_reg: got iv=%b wv=%b op=%h count=%0d expected 1 0 05 1", instr_valid, weight_valid, instr_opcode, count); end
      in_bits = mk(24'h333, 16'h33, 32'h30, 8'hC3);
      step();
      in_valid = 1'b0;
      n_checks++; if (weight_valid !== 1'b1 || instr_valid !== 1'b0 || weight_addr !== 40'h0003330033 || count !== 4'd1) begin n_fail++; $display("FAIL b2b_wt: got wv=%b iv=%b addr=%h count=%0d expected 1 0 0003330033 1", weight_valid, instr_valid, weight_addr, count); end
      step();
      n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL b2b_drain: got empty=%b expected 1", empty); end
      instr_ready = 1'b0; weight_ready = 1'b0;
   endtask

   task automatic test_hol_blocking();
      instr_ready = 1'b1; weight_ready = 1'b0;
      in_valid = 1'b1; in_bits = mk(24'h444, 16'h44, 32'h40, 8'h90);
      step();
      in_bits = mk(24'h555, 16'h55, 32'h50, 8'h07);
      step();
      in_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         n_checks++; if (instr_valid !== 1'b0 || weight_valid !== 1'b1 || count !== 4'd2) begin n_fail++; $display("FAIL hol_block[%0d]: got iv=%b wv=%b count=%0d expected 0 1 2", i, instr_valid, weight_valid, count); end
         step();
      end
      weight_ready = 1'b1;
      step();
      n_checks++; if (instr_valid !== 1'b1 || weight_valid !== 1'b0 || instr_opcode !== 8'h07 || count !== 4'd1) begin n_fail++; $display("FAIL hol_release: got iv=%b wv=%b op=%h count=%0d expected 1 0 07 1", instr_valid, weight_valid, instr_opcode, count); end
      step();
      n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL hol_drain: got empty=%b expected 1", empty); end
      instr_ready = 1'b0; weight_ready = 1'b0;
   endtask

   task automatic test_full();
      logic [7:0] exp_op [7];
      for (int i = 1; i <= 8; i++) begin
         in_valid = 1'b1; in_bits = mk(24'(i), 16'(i), 32'(i), 8'(i));
         step();
      end
      n_checks++; if (full !== 1'b1 || count !== 4'd8 || in_ready !== 1'b0 || empty !== 1'b0) begin n_fail++; $display("FAIL full_state: got full=%b count=%0d in_ready=%b empty=%b expected 1 8 0 0", full, count, in_ready, empty); end
      in_bits = mk(24'hFFF, 16'hFF, 32'hAA, 8'h7F);
      step();
      n_checks++; if (count !== 4'd8 || instr_opcode !== 8'h01 || instr_length !== 32'h1) begin n_fail++; $display("FAIL full_reject: got count=%0d op=%h len=%h expected 8 01 00000001", count, instr_opcode, instr_length); end
      instr_ready = 1'b1;
      step();
      n_checks++; if (count !== 4'd7 || full !== 1'b0 || instr_opcode !== 8'h02) begin n_fail++; $display("FAIL full_pop_push: got count=%0d full=%b op=%h expected 7 0 02", count, full, instr_opcode); end
      step();
      in_valid = 1'b0;
      n_checks++; if (count !== 4'd7 || instr_opcode !== 8'h03) begin n_fail++; $display("FAIL simul_push_pop: got count=%0d op=%h expected 7 03", count, instr_opcode); end
      exp_op = '{8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h7F};
      for (int k = 0; k < 7; k++) begin
         n_checks++; if (instr_valid !== 1'b1 || instr_opcode !== exp_op[k]) begin n_fail++; $display("FAIL drain_order[%0d]: got valid=%b op=%h expected 1 %h", k, instr_valid, instr_opcode, exp_op[k]); end
         step();
      end
      n_checks++; if (empty !== 1'b1 || count !== 4'd0) begin n_fail++; $display("FAIL full_drained: got empty=%b count=%0d expected 1 0", empty, count); end
      instr_ready = 1'b0;
   endtask

   task automatic test_flush();
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1; in_bits = mk(24'h600 + 24'(i), 16'h6, 32'h6, 8'h11);
         step();
      end
      n_checks++; if (count !== 4'd5) begin n_fail++; $display("FAIL flush_pre: got count=%0d expected 5", count); end
      flush = 1'b1; instr_ready = 1'b1; in_bits = mk(24'h777, 16'h7, 32'h7, 8'h12);
      step();
      flush = 1'b0; in_valid = 1'b0; instr_ready = 1'b0;
      n_checks++; if (count !== 4'd0 || empty !== 1'b1 || instr_valid !== 1'b0) begin n_fail++; $display("FAIL flush_clear: got count=%0d empty=%b iv=%b expected 0 1 0", count, empty, instr_valid); end
      in_valid = 1'b1; in_bits = mk(24'h888, 16'h8, 32'h8, 8'h13);
      step();
      in_valid = 1'b0;
      n_checks++; if (instr_valid !== 1'b1 || instr_buffer_addr !== 24'h888 || count !== 4'd1) begin n_fail++; $display("FAIL flush_after: got iv=%b baddr=%h count=%0d expected 1 000888 1", instr_valid, instr_buffer_addr, count); end
      instr_ready = 1'b1;
      step();
      instr_ready = 1'b0;
   endtask

   task automatic test_async_reset();
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1; in_bits = mk(24'h900, 16'h9, 32'h9, 8'h85);
         step();
      end
      in_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      n_checks++; if (count !== 4'd0 || empty !== 1'b1 || full !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL arst_status: got count=%0d empty=%b full=%b in_ready=%b expected 0 1 0 1", count, empty, full, in_ready); end
      n_checks++; if (instr_valid !== 1'b0 || weight_valid !== 1'b0) begin n_fail++; $display("FAIL arst_valids: got %b%b expected 00", instr_valid, weight_valid); end
      step();
      rst_n = 1'b1;
      in_valid = 1'b1; in_bits = mk(24'hA00, 16'hA, 32'hA, 8'h21);
      step();
      in_valid = 1'b0;
      n_checks++; if (count !== 4'd1 || instr_valid !== 1'b1 || instr_opcode !== 8'h21) begin n_fail++; $display("FAIL arst_first_push: got count=%0d iv=%b op=%h expected 1 1 21", count, instr_valid, instr_opcode); end
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; in_bits = '0; flush = 1'b0;
      instr_ready = 1'b0; weight_ready = 1'b0;
      test_reset();
      test_regular();
      test_weight();
      test_back_to_back();
      test_hol_blocking();
      test_full();
      test_flush();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
